// File: rtl/onehot_rr_scheduler.sv
// ----------------------------------------------------------------------------
// onehot_rr_scheduler
//
// Round-robin scheduler that shares one resource between N requesters.
// Priority is kept as a one-hot rotating pointer. When a requester wins,
// the pointer moves to the bit just above the winner, wrapping N-1 -> 0.
// A grant is held for as long as the winner keeps its request high.
// Between two grants there is always at least one idle (dead) cycle.
//
// Optional feature (macro ONEHOT_SCHED_TIMEOUT_EN):
//   When the macro is defined, a hold counter limits a grant to MAX_HOLD
//   cycles. When the limit is reached, the grant is forced off and the
//   timeout output pulses high for one cycle. When the macro is not
//   defined, timeout is tied to 0 and a grant is held indefinitely.
//
// Parameters:
//   N         number of requesters (>=1)
//   MAX_HOLD  maximum consecutive BUSY cycles per grant (timeout build, >=2)
//   HOLD_W    hold-counter width, 2**HOLD_W > MAX_HOLD
//
// Ports:
//   clk          in   rising-edge clock
//   rst          in   synchronous reset, active-high
//   enable       in   allows new arbitration; has no effect on a held grant
//   req          in   [N-1:0] request vector
//   grant        out  [N-1:0] one-hot grant, or zero when idle
//   grant_valid  out  high when grant is non-zero
//   grant_idx    out  binary index of the granted requester, 0 when idle
//   ptr          out  [N-1:0] one-hot priority pointer
//   timeout      out  one-cycle pulse on a forced release
// ----------------------------------------------------------------------------
module onehot_rr_scheduler #(
  parameter int N        = 8,
  parameter int MAX_HOLD = 16,
  parameter int HOLD_W   = 8,
  localparam int IDX_W   = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [N-1:0]     req,
  output logic [N-1:0]     grant,
  output logic             grant_valid,
  output logic [IDX_W-1:0] grant_idx,
  output logic [N-1:0]     ptr,
  output logic             timeout
);

  // Reject unusable parameter sets when the design is elaborated.
  if (N < 1 || MAX_HOLD < 2 || (2 ** HOLD_W) <= MAX_HOLD) begin : g_bad_params
    $error("onehot_rr_scheduler: illegal parameter combination");
  end

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state, state_nxt;
  logic [N-1:0]     grant_nxt;
  logic             valid_nxt;
  logic [IDX_W-1:0] idx_nxt;
  logic [N-1:0]     ptr_nxt;

  // Arbitration signals
  int               ptr_pos;
  int               win_pos;
  int               rot_pos;
  logic             win_found;
  logic [N-1:0]     win_oh;
  logic [N-1:0]     win_rot;
  logic             held;

  // The winner's request line decides whether the grant is kept.
  assign held = |(req & grant);

  // Search the request vector starting at the pointer position and moving
  // upward, wrapping from N-1 back to 0. The first set request wins.
  always_comb begin
    ptr_pos   = 0;
    win_pos   = 0;
    rot_pos   = 0;
    win_found = 1'b0;
    win_oh    = '0;
    win_rot   = '0;
    for (int i = 0; i < N; i++) begin
      if (ptr[i]) ptr_pos = i;
    end
    for (int k = 0; k < N; k++) begin
      int pos;
      pos = ptr_pos + k;
      if (pos >= N) pos = pos - N;
      if (!win_found && req[pos]) begin
        win_found = 1'b1;
        win_pos   = pos;
      end
    end
    win_oh[win_pos] = 1'b1;
    // The pointer moves to the bit just above the winner. With N=1 this
    // keeps the pointer at bit 0.
    rot_pos = win_pos + 1;
    if (rot_pos >= N) rot_pos = 0;
    win_rot[rot_pos] = 1'b1;
  end

`ifdef ONEHOT_SCHED_TIMEOUT_EN
  logic [HOLD_W-1:0] hold_cnt, hold_cnt_nxt;
  logic              timeout_nxt;
  logic              hold_limit;

  assign hold_limit = (hold_cnt == HOLD_W'(MAX_HOLD - 1));
`endif

  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    valid_nxt = grant_valid;
    idx_nxt   = grant_idx;
    ptr_nxt   = ptr;
`ifdef ONEHOT_SCHED_TIMEOUT_EN
    timeout_nxt  = 1'b0;
    hold_cnt_nxt = hold_cnt;
`endif
    case (state)
      IDLE: begin
        if (enable && win_found) begin
          state_nxt = BUSY;
          grant_nxt = win_oh;
          valid_nxt = 1'b1;
          idx_nxt   = IDX_W'(win_pos);
          ptr_nxt   = win_rot;
`ifdef ONEHOT_SCHED_TIMEOUT_EN
          hold_cnt_nxt = '0;
`endif
        end
      end
      BUSY: begin
        // A normal release has priority over the hold limit on the same edge.
        if (!held) begin
          state_nxt = IDLE;
          grant_nxt = '0;
          valid_nxt = 1'b0;
          idx_nxt   = '0;
        end
`ifdef ONEHOT_SCHED_TIMEOUT_EN
        else if (hold_limit) begin
          state_nxt   = IDLE;
          grant_nxt   = '0;
          valid_nxt   = 1'b0;
          idx_nxt     = '0;
          timeout_nxt = 1'b1;
        end else begin
          hold_cnt_nxt = hold_cnt + 1'b1;
        end
`endif
      end
      default: begin
        state_nxt = IDLE;
        grant_nxt = '0;
        valid_nxt = 1'b0;
        idx_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      grant       <= '0;
      grant_valid <= 1'b0;
      grant_idx   <= '0;
      ptr         <= N'(1);
    end else begin
      state       <= state_nxt;
      grant       <= grant_nxt;
      grant_valid <= valid_nxt;
      grant_idx   <= idx_nxt;
      ptr         <= ptr_nxt;
    end
  end

`ifdef ONEHOT_SCHED_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      hold_cnt <= hold_cnt_nxt;
      timeout  <= timeout_nxt;
    end
  end
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_onehot_rr_scheduler.sv
// Directed bench for onehot_rr_scheduler with N=4 and MAX_HOLD=4.
// A table of single-cycle vectors covers the basic behaviour. Hand-written
// sequences cover rotation fairness and hold-limit behaviour.
module tb_onehot_rr_scheduler;

  localparam int N        = 4;
  localparam int MAX_HOLD = 4;
  localparam int HOLD_W   = 8;

  logic       clk;
  logic       rst;
  logic       enable;
  logic [3:0] req;
  logic [3:0] grant;
  logic       grant_valid;
  logic [1:0] grant_idx;
  logic [3:0] ptr;
  logic       timeout;

  int n_cmp;
  int n_err;

  onehot_rr_scheduler #(
    .N(N), .MAX_HOLD(MAX_HOLD), .HOLD_W(HOLD_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .req        (req),
    .grant      (grant),
    .grant_valid(grant_valid),
    .grant_idx  (grant_idx),
    .ptr        (ptr),
    .timeout    (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       rst;
    logic       enable;
    logic [3:0] req;
    logic [3:0] grant;
    logic [1:0] idx;
    logic       valid;
    logic [3:0] ptr;
    logic       tmo;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Inputs change on the falling edge. Outputs are sampled 1 ns after the
  // following rising edge.
  task automatic step(input logic r, input logic e, input logic [3:0] q);
    @(negedge clk);
    rst    = r;
    enable = e;
    req    = q;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string name, input logic [3:0] g, input logic [1:0] i,
                           input logic v, input logic [3:0] p, input logic t);
    check({name, ".grant"},       32'(grant),       32'(g));
    check({name, ".grant_idx"},   32'(grant_idx),   32'(i));
    check({name, ".grant_valid"}, 32'(grant_valid), 32'(v));
    check({name, ".ptr"},         32'(ptr),         32'(p));
    check({name, ".timeout"},     32'(timeout),     32'(t));
  endtask

  initial begin
    logic [3:0] exp_g;
    logic [3:0] exp_p;
    n_cmp  = 0;
    n_err  = 0;
    rst    = 1'b1;
    enable = 1'b0;
    req    = 4'b0000;

    //                name         rst  en   req      grant    idx  vld  ptr      tmo
    vecs.push_back('{"reset",      1'b1, 1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, 4'b0001, 1'b0});
    vecs.push_back('{"idle0",      1'b0, 1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, 4'b0001, 1'b0});
    vecs.push_back('{"idle1",      1'b0, 1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, 4'b0001, 1'b0});
    vecs.push_back('{"idle2",      1'b0, 1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, 4'b0001, 1'b0});
    vecs.push_back('{"idle3",      1'b0, 1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, 4'b0001, 1'b0});
    vecs.push_back('{"g1010",      1'b0, 1'b1, 4'b1010, 4'b0010, 2'd1, 1'b1, 4'b0100, 1'b0});
    vecs.push_back('{"hold1010",   1'b0, 1'b1, 4'b1010, 4'b0010, 2'd1, 1'b1, 4'b0100, 1'b0});
    vecs.push_back('{"rel1",       1'b0, 1'b1, 4'b1000, 4'b0000, 2'd0, 1'b0, 4'b0100, 1'b0});
    vecs.push_back('{"g1000",      1'b0, 1'b1, 4'b1000, 4'b1000, 2'd3, 1'b1, 4'b0001, 1'b0});
    vecs.push_back('{"rel3",       1'b0, 1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, 4'b0001, 1'b0});
    vecs.push_back('{"dis0",       1'b0, 1'b0, 4'b0100, 4'b0000, 2'd0, 1'b0, 4'b0001, 1'b0});
    vecs.push_back('{"dis1",       1'b0, 1'b0, 4'b0100, 4'b0000, 2'd0, 1'b0, 4'b0001, 1'b0});
    vecs.push_back('{"en_g0100",   1'b0, 1'b1, 4'b0100, 4'b0100, 2'd2, 1'b1, 4'b1000, 1'b0});
    vecs.push_back('{"busy_dis0",  1'b0, 1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1, 4'b1000, 1'b0});
    vecs.push_back('{"busy_dis1",  1'b0, 1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1, 4'b1000, 1'b0});
    vecs.push_back('{"rel_rise",   1'b0, 1'b1, 4'b0011, 4'b0000, 2'd0, 1'b0, 4'b1000, 1'b0});
    vecs.push_back('{"wrap_g0001", 1'b0, 1'b1, 4'b0011, 4'b0001, 2'd0, 1'b1, 4'b0010, 1'b0});
    vecs.push_back('{"rel0",       1'b0, 1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, 4'b0010, 1'b0});
    vecs.push_back('{"g0100",      1'b0, 1'b1, 4'b0100, 4'b0100, 2'd2, 1'b1, 4'b1000, 1'b0});
    vecs.push_back('{"rst_busy",   1'b1, 1'b1, 4'b0100, 4'b0000, 2'd0, 1'b0, 4'b0001, 1'b0});
    vecs.push_back('{"post_rst",   1'b0, 1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, 4'b0001, 1'b0});

    foreach (vecs[n]) begin
      step(vecs[n].rst, vecs[n].enable, vecs[n].req);
      check_all(vecs[n].name, vecs[n].grant, vecs[n].idx, vecs[n].valid, vecs[n].ptr, vecs[n].tmo);
    end

    // Rotation with all requesters active. Each owner drops its request
    // two cycles after the grant and re-raises it immediately afterwards.
    step(1'b1, 1'b1, 4'b0000);
    for (int g = 0; g < 5; g++) begin
      exp_g = 4'b0001 << (g % 4);
      exp_p = 4'b0001 << ((g + 1) % 4);
      step(1'b0, 1'b1, 4'b1111);
      check_all($sformatf("rr%0d.grant", g), exp_g, 2'(g % 4), 1'b1, exp_p, 1'b0);
      step(1'b0, 1'b1, 4'b1111);
      check($sformatf("rr%0d.held", g), 32'(grant), 32'(exp_g));
      step(1'b0, 1'b1, 4'b1111 & ~exp_g);
      check_all($sformatf("rr%0d.dead", g), 4'b0000, 2'd0, 1'b0, exp_p, 1'b0);
    end

    // Two requesters held high indefinitely.
    step(1'b1, 1'b1, 4'b0000);
    step(1'b0, 1'b1, 4'b0011);
    check_all("hog.grant", 4'b0001, 2'd0, 1'b1, 4'b0010, 1'b0);
`ifdef ONEHOT_SCHED_TIMEOUT_EN
    for (int c = 0; c < MAX_HOLD - 1; c++) begin
      step(1'b0, 1'b1, 4'b0011);
      check_all($sformatf("hog.held%0d", c), 4'b0001, 2'd0, 1'b1, 4'b0010, 1'b0);
    end
    step(1'b0, 1'b1, 4'b0011);
    check_all("hog.forced", 4'b0000, 2'd0, 1'b0, 4'b0010, 1'b1);
    step(1'b0, 1'b1, 4'b0011);
    check_all("hog.next", 4'b0010, 2'd1, 1'b1, 4'b0100, 1'b0);

    // A normal release on the limit edge produces no timeout pulse.
    step(1'b1, 1'b1, 4'b0000);
    step(1'b0, 1'b1, 4'b0001);
    check_all("lim.grant", 4'b0001, 2'd0, 1'b1, 4'b0010, 1'b0);
    for (int c = 0; c < MAX_HOLD - 1; c++) begin
      step(1'b0, 1'b1, 4'b0001);
      check($sformatf("lim.held%0d", c), 32'(grant), 32'(4'b0001));
    end
    step(1'b0, 1'b1, 4'b0000);
    check_all("lim.release", 4'b0000, 2'd0, 1'b0, 4'b0010, 1'b0);
    step(1'b0, 1'b1, 4'b0000);
    check("lim.after", 32'(timeout), 32'(0));
`else
    for (int c = 0; c < 20; c++) begin
      step(1'b0, 1'b1, 4'b0011);
      check_all($sformatf("hog.held%0d", c), 4'b0001, 2'd0, 1'b1, 4'b0010, 1'b0);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
